// File: rtl/kernel_pkg.sv
// Shared types and constants for the 3x3 kernel window loader.
package kernel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_PRESENT,
        ST_FINISH
    } state_t;

    localparam int K_CENTER = 4;
    localparam int K_COUNT  = 9;
    localparam int BYTE_W   = 8;
    localparam int WIN_W    = K_COUNT * BYTE_W;

    // Neighbourhood offsets in fetch order: dc varies fastest, so reads are row-major.
    localparam int DR_TAB [K_COUNT] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int DC_TAB [K_COUNT] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/kernel_addr_gen.sv
// Maps a centre pixel (r,c) and neighbour index k to a row-major RAM address.
module kernel_addr_gen
    import kernel_pkg::*;
#(
    parameter int N       = 8,
    parameter int bitSize = 6
) (
    input  logic [bitSize:0] r,
    input  logic [bitSize:0] c,
    input  logic [3:0]       k,
    output logic [bitSize:0] addr
);

    int row_i;
    int col_i;
    int lin_i;

    // (r+dr)*N + (c+dc); r,c stay inside 1..N-2 so the result never wraps.
    always_comb begin
        row_i = int'(r) + DR_TAB[k];
        col_i = int'(c) + DC_TAB[k];
        lin_i = row_i * N + col_i;
        addr  = lin_i[bitSize:0];
    end

endmodule

// File: rtl/kernel_window_loader.sv
// Scans interior pixels of a padded N x N image, fetching each 3x3 window
// with one read per cycle and presenting it on a valid/ready port.
module kernel_window_loader
    import kernel_pkg::*;
#(
    parameter int N       = 8,
    parameter int bitSize = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               ram_re,
    output logic [bitSize:0]   ram_addr,
    input  logic [7:0]         ram_data,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [WIN_W-1:0]   win_data,
    output logic [bitSize:0]   win_center
);

    localparam int AW = bitSize + 1;
    localparam logic [AW-1:0] RC_FIRST = AW'(1);
    localparam logic [AW-1:0] RC_LAST  = AW'(N - 2);
    localparam logic [3:0]    K_LAST   = 4'(K_COUNT - 1);
    localparam logic [3:0]    K_MID    = 4'(K_CENTER);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   r;
    logic [AW-1:0]   c;
    logic [3:0]      k;
    logic [3:0]      k_prev;
    logic [AW-1:0]   gen_addr;
    logic [AW-1:0]   addr_hold;
    logic            hs;
    logic            last_pix;

    assign hs       = (state == ST_PRESENT) && win_ready;
    assign last_pix = (r == RC_LAST) && (c == RC_LAST);
    assign k_prev   = k - 4'd1;

    kernel_addr_gen #(
        .N       (N),
        .bitSize (bitSize)
    ) u_addr_gen (
        .r    (r),
        .c    (c),
        .k    (k),
        .addr (gen_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        ram_re    = 1'b0;
        win_valid = 1'b0;
        ram_addr  = addr_hold;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                ram_re   = 1'b1;
                ram_addr = gen_addr;
                if (k == K_LAST) state_nxt = ST_LAST;
            end
            ST_LAST: begin
                state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) state_nxt = last_pix ? ST_FINISH : ST_FETCH;
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Scan position, fetch counter and window assembly (read data lags the address by one cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= RC_FIRST;
            c          <= RC_FIRST;
            k          <= '0;
            addr_hold  <= '0;
            win_data   <= '0;
            win_center <= '0;
        end else begin
            if (state == ST_FETCH) begin
                k         <= (k == K_LAST) ? 4'd0 : k + 4'd1;
                addr_hold <= gen_addr;
                if (k != 4'd0) win_data[k_prev*BYTE_W +: BYTE_W] <= ram_data;
                if (k == K_MID) win_center <= gen_addr;
            end
            if (state == ST_LAST) begin
                win_data[(K_COUNT-1)*BYTE_W +: BYTE_W] <= ram_data;
            end
            if (hs && !last_pix) begin
                if (c == RC_LAST) begin
                    c <= RC_FIRST;
                    r <= r + AW'(1);
                end else begin
                    c <= c + AW'(1);
                end
            end
            if (state == ST_FINISH) begin
                r <= RC_FIRST;
                c <= RC_FIRST;
            end
        end
    end

endmodule

// File: doc/kernel_window_loader.md
Name: kernel_window_loader

Overview:
- Initiator side of the kernel-RAM interface: walks a padded N x N image held in the image RAM and fetches the 3x3 neighbourhood of every interior pixel.
- Issues one read per cycle and assembles the 9 returned bytes into a window.
- Presents each window with a valid/ready handshake to the centerMask/kernel units.
- Sits between the image RAM read port and the convolutional units.

Parameters:
- N, 8, padded image side length in pixels (N >= 3); border rows and columns are padding.
- bitSize, 6, address MSB index; addresses are [bitSize:0]; requires 2^(bitSize+1) >= N*N.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a full-image scan; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last window handshake.
- ram_re  output  1  image RAM read enable.
- ram_addr  output  bitSize+1  image RAM read address, row-major (r*N+c).
- ram_data  input  8  image RAM read data; valid the cycle after ram_re (1-cycle latency).
- win_valid  output  1  window available.
- win_ready  input  1  consumer accepts window.
- win_data  output  72  window bytes; byte k at [8k+7:8k], k=(dr+1)*3+(dc+1), dr,dc in {-1,0,1}; k=4 is the centre.
- win_center  output  bitSize+1  address of the centre pixel.

Behaviour:
- Reset: state IDLE, r=c=1, all outputs 0 (busy, done, ram_re, ram_addr, win_valid, win_data, win_center). Reset mid-scan abandons the scan with no done pulse.
- States: IDLE, FETCH, LAST, PRESENT, FINISH.
- IDLE:
  - start=1 -> FETCH with k=0.
  - start is ignored in every other state.
- FETCH (9 cycles, k=0..8):
  - ram_re=1, ram_addr=(r+dr(k))*N+(c+dc(k)).
  - From the second FETCH cycle onward, capture ram_data into byte k-1.
  - At k=8 -> LAST.
- LAST (1 cycle): ram_re=0; capture ram_data into byte 8 -> PRESENT.
- PRESENT:
  - win_valid=1; win_data and win_center held stable until the win_valid & win_ready edge.
  - On handshake with (r,c)=(N-2,N-2) -> FINISH.
  - Otherwise: c=c+1, or c=1 and r=r+1 when c=N-2; then -> FETCH with k=0.
  - win_valid drops the cycle after the handshake.
- FINISH (1 cycle): done=1, r=c=1 -> IDLE.
- Latency:
  - start seen in cycle 0; FETCH runs cycles 1-9; LAST is cycle 10; win_valid=1 in cycle 11 when ready is held high.
  - Each subsequent window arrives 11 cycles after the previous handshake.
  - Scan produces (N-2)^2 windows; 36 for N=8.
- ram_data is captured only in FETCH cycles k>=1 and in LAST; all other cycles ignore it.
- Address arithmetic in unsigned bitSize+1 bits; no wrap possible because r,c are in 1..N-2.
- ram_addr holds its last value while ram_re=0; consumers must not rely on this.

Decomposition:
- Shared package kernel_pkg holds:
  - state enum;
  - K_CENTER=4, K_COUNT=9;
  - constant dr/dc offset tables indexed by k;
  - window byte-width constant.
- One sub-module, kernel_addr_gen: combinational, maps (r,c,k) to ram_addr using the package offset tables.

Test Plan:
- Reset: rst high 3 cycles mid-FETCH -> all outputs 0 the next cycle, state IDLE, no done pulse.
- First window (N=8): RAM model returns data=address; start pulsed in cycle 0, win_ready=1 -> read addresses 0,1,2,8,9,10,16,17,18 in cycles 1-9; win_valid in cycle 11 with bytes {0,1,2,8,9,10,16,17,18}, win_center=9.
- Backpressure: win_ready low for 5 cycles after win_valid -> win_data/win_center unchanged, ram_re=0 throughout; ready high -> next FETCH begins with centre 10 (addresses 1,2,3,9,10,11,17,18,19).
- Row wrap: window following centre 14 (r=1,c=6) has centre 17 (r=2,c=1), first read address 8.
- Full scan, random ready: exactly 36 handshakes, last centre 54; done high for exactly one cycle, after the last handshake; busy returns to 0.
- start held high during a scan -> ignored; no restart; new scan only after return to IDLE.
